// File: rtl/power_mode_ctrl_if.sv
// rtl/power_mode_ctrl_if.sv - power-mode controller event inputs and mode/score outputs
interface power_mode_ctrl_if;
  logic        frame_tick;
  logic        ate_pellet;
  logic        new_map;
  logic        pacman_died;
  logic [3:0]  ghost_caught;
  logic        pellet_ack;
  logic [3:0]  frightened;
  logic        flash;
  logic        freeze;
  logic        bonus_valid;
  logic [11:0] bonus_points;
  logic        maze_flash;
  logic        level_start;
  logic [1:0]  state;

  modport master (
    output frame_tick, ate_pellet, new_map, pacman_died, ghost_caught,
    input  pellet_ack, frightened, flash, freeze, bonus_valid, bonus_points,
           maze_flash, level_start, state
  );

  modport slave (
    input  frame_tick, ate_pellet, new_map, pacman_died, ghost_caught,
    output pellet_ack, frightened, flash, freeze, bonus_valid, bonus_points,
           maze_flash, level_start, state
  );
endinterface

// File: rtl/power_mode_ctrl.sv
// rtl/power_mode_ctrl.sv - power-pellet, ghost-eaten bonus chain and level-clear sequencer
module power_mode_ctrl #(
  parameter int POWER_FRAMES  = 360,
  parameter int WARN_FRAMES   = 120,
  parameter int FLASH_PERIOD  = 15,
  parameter int FREEZE_FRAMES = 30,
  parameter int CLEAR_FRAMES  = 120
) (
  input logic             Clk,
  input logic             Reset,
  power_mode_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, POWER = 2'd1, FREEZE = 2'd2, CLEAR = 2'd3} state_t;

  localparam logic [9:0] POWER_LD  = 10'(POWER_FRAMES);
  localparam logic [9:0] WARN_LD   = 10'(WARN_FRAMES);
  localparam logic [7:0] FP_LAST   = 8'(FLASH_PERIOD - 1);
  localparam logic [7:0] FREEZE_LD = 8'(FREEZE_FRAMES);
  localparam logic [7:0] CLEAR_LD  = 8'(CLEAR_FRAMES);
  localparam logic [7:0] MAZE_LAST = 8'd14;

  state_t      st;
  logic [9:0]  timer;
  logic [7:0]  aux;
  logic [1:0]  combo;
  logic [7:0]  fcnt;
  logic        ate_q;
  logic        nm_block;
  logic [3:0]  frightened_q;
  logic        flash_q, freeze_q, pellet_ack_q, bonus_valid_q, maze_flash_q, level_start_q;
  logic [11:0] bonus_points_q;

  logic       pellet_rise, nm_go, in_power;
  logic [3:0] cand, catch_oh;
  logic [9:0] t_dec;

  assign pellet_rise = bus.ate_pellet & ~ate_q;
  // new_map must be seen low after a clear before it can start another one
  assign nm_go       = bus.new_map & ~nm_block & (st != CLEAR);
  assign in_power    = (st == POWER) || (st == FREEZE);
  assign cand        = bus.ghost_caught & frightened_q;
  assign catch_oh    = cand & (~cand + 4'd1);
  assign t_dec       = timer - 10'd1;

  assign bus.pellet_ack   = pellet_ack_q;
  assign bus.frightened   = frightened_q;
  assign bus.flash        = flash_q;
  assign bus.freeze       = freeze_q;
  assign bus.bonus_valid  = bonus_valid_q;
  assign bus.bonus_points = bonus_points_q;
  assign bus.maze_flash   = maze_flash_q;
  assign bus.level_start  = level_start_q;
  assign bus.state        = st;

  always_ff @(posedge Clk) begin
    pellet_ack_q  <= 1'b0;
    bonus_valid_q <= 1'b0;
    level_start_q <= 1'b0;
    if (Reset) begin
      st             <= IDLE;
      timer          <= '0;
      aux            <= '0;
      combo          <= '0;
      fcnt           <= '0;
      ate_q          <= 1'b0;
      nm_block       <= 1'b0;
      frightened_q   <= '0;
      flash_q        <= 1'b0;
      freeze_q       <= 1'b0;
      maze_flash_q   <= 1'b0;
      bonus_points_q <= '0;
    end else begin
      ate_q <= bus.ate_pellet;
      if (!bus.new_map) nm_block <= 1'b0;

      if (nm_go) begin
        st           <= CLEAR;
        frightened_q <= '0;
        flash_q      <= 1'b0;
        freeze_q     <= 1'b1;
        maze_flash_q <= 1'b0;
        aux          <= CLEAR_LD;
        timer        <= '0;
        fcnt         <= '0;
        nm_block     <= 1'b1;
      end else if (bus.pacman_died && st != CLEAR) begin
        st           <= IDLE;
        frightened_q <= '0;
        flash_q      <= 1'b0;
        freeze_q     <= 1'b0;
        maze_flash_q <= 1'b0;
        combo        <= '0;
        timer        <= '0;
        aux          <= '0;
        fcnt         <= '0;
      end else if (pellet_rise && st != CLEAR) begin
        // a re-arm during FREEZE leaves the running freeze in place
        if (st == IDLE) st <= POWER;
        frightened_q <= 4'hF;
        timer        <= POWER_LD;
        combo        <= '0;
        flash_q      <= 1'b0;
        fcnt         <= '0;
        pellet_ack_q <= 1'b1;
      end else if (in_power && (cand != 4'd0)) begin
        frightened_q   <= frightened_q & ~catch_oh;
        bonus_points_q <= 12'd200 << combo;
        bonus_valid_q  <= 1'b1;
        if (combo != 2'd3) combo <= combo + 2'd1;
        st       <= FREEZE;
        freeze_q <= 1'b1;
        aux      <= FREEZE_LD;
      end else if (bus.frame_tick) begin
        case (st)
          POWER: begin
            if (timer == 10'd1) begin
              st           <= IDLE;
              frightened_q <= '0;
              flash_q      <= 1'b0;
              timer        <= '0;
              fcnt         <= '0;
            end else begin
              timer <= t_dec;
              // fcnt counts frames within a flash phase; the phase parity is flash itself
              if (t_dec == WARN_LD) begin
                flash_q <= 1'b1;
                fcnt    <= '0;
              end else if (t_dec < WARN_LD) begin
                if (fcnt == FP_LAST) begin
                  fcnt    <= '0;
                  flash_q <= ~flash_q;
                end else begin
                  fcnt <= fcnt + 8'd1;
                end
              end
            end
          end
          FREEZE: begin
            if (aux == 8'd1) begin
              aux      <= '0;
              freeze_q <= 1'b0;
              if (frightened_q == 4'd0) begin
                st      <= IDLE;
                flash_q <= 1'b0;
                timer   <= '0;
                fcnt    <= '0;
              end else begin
                st <= POWER;
              end
            end else begin
              aux <= aux - 8'd1;
            end
          end
          CLEAR: begin
            if (aux == 8'd1) begin
              st            <= IDLE;
              aux           <= '0;
              freeze_q      <= 1'b0;
              maze_flash_q  <= 1'b0;
              level_start_q <= 1'b1;
              fcnt          <= '0;
            end else begin
              aux <= aux - 8'd1;
              if (fcnt == MAZE_LAST) begin
                fcnt         <= '0;
                maze_flash_q <= ~maze_flash_q;
              end else begin
                fcnt <= fcnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/power_mode_ctrl.md
# power_mode_ctrl

Sequencer for the maze's power-pellet and level-clear behaviour. It consumes the point/pellet tracker's `ate_pellet` and `new_map` flags and ghost collision reports. It drives per-ghost frightened state, the warning flash, the ghost-eaten bonus chain, the gameplay freeze and the level-clear pause. It sits between the point/pellet tracker, the ghost movers and the score accumulator, and is clocked on `Clk` with frame-rate timing taken from a one-cycle `frame_tick`.

## Interface
Parameters:
- POWER_FRAMES, 360, frightened duration in frames (2..1023)
- WARN_FRAMES, 120, final frames of power during which `flash` is active (< POWER_FRAMES)
- FLASH_PERIOD, 15, frames per flash phase (≥1)
- FREEZE_FRAMES, 30, gameplay freeze after a ghost is eaten (≥1)
- CLEAR_FRAMES, 120, level-clear pause length (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-Clk pulse per video frame
- ate_pellet  in  1  level from the pellet tracker; high from pellet eaten until acknowledged
- new_map  in  1  level, high while all points are cleared
- pacman_died  in  1  one-cycle pulse
- ghost_caught  in  4  per-ghost overlap with Pac-Man, level
- pellet_ack  out  1  one-cycle pulse that clears `ate_pellet` upstream
- frightened  out  4  per-ghost frightened flag
- flash  out  1  frightened ghosts render white
- freeze  out  1  movers must hold position
- bonus_valid  out  1  one-cycle pulse; add `bonus_points` to the score
- bonus_points  out  12  200, 400, 800 or 1600
- maze_flash  out  1  maze wall colour toggle during level clear
- level_start  out  1  one-cycle pulse at the end of level clear
- state  out  2  0 = IDLE, 1 = POWER, 2 = FREEZE, 3 = CLEAR

## Operation
- Registers:
  - `timer` (10b): power frames remaining
  - `aux` (8b): freeze/clear frame counter
  - `combo` (2b): bonus chain position, saturating
  - `fcnt` (8b): flash phase counter
  - `ate_q`: previous `ate_pellet`, for rise detection
- The pellet trigger is the rise of `ate_pellet` (`ate_pellet & ~ate_q`).
- Priority per cycle, highest first: Reset > new_map > pacman_died > pellet rise > ghost capture > frame_tick counting.
- IDLE: `frightened`=0, `flash`=0, `freeze`=0.
  - Pellet rise → POWER, `frightened`=4'hF, `timer`=POWER_FRAMES, `combo`=0, `pellet_ack`=1.
- POWER:
  - Each `frame_tick` decrements `timer`.
  - A tick with `timer`==1 → IDLE with `frightened`=0.
- Ghost capture (state POWER or FREEZE):
  - Candidates are `ghost_caught & frightened`; the lowest-index candidate is served in that cycle.
  - `frightened[i]` clears; `bonus_points` = 200 << `combo`; `bonus_valid`=1.
  - `combo` increments, saturating at 3.
  - State → FREEZE with `aux`=FREEZE_FRAMES.
  - A remaining candidate is served on the next cycle if still asserted; each service restarts `aux`.
  - Captures of non-frightened ghosts are ignored here; death handling is elsewhere.
- FREEZE: `freeze`=1 and `timer` is paused.
  - Each tick decrements `aux`.
  - A tick with `aux`==1 → POWER.
  - If `frightened` has become 0, the same tick → IDLE instead.
- Pellet rise in POWER or FREEZE re-arms the mode:
  - `frightened`=4'hF (eaten ghosts included), `timer`=POWER_FRAMES, `combo`=0, `flash`=0, `pellet_ack`=1.
  - State is unchanged: a running freeze continues.
- Flash: `flash`=1 iff state ∈ {POWER, FREEZE} and `timer` ≤ WARN_FRAMES and ⌊(WARN_FRAMES − `timer`)/FLASH_PERIOD⌋ is even. `fcnt` implements the division; no divider is used.
- new_map high (any state except CLEAR) → CLEAR:
  - `frightened`=0, `freeze`=1, `aux`=CLEAR_FRAMES, `maze_flash`=0.
  - In CLEAR, `maze_flash` toggles every 15 ticks.
  - The tick with `aux`==1 → IDLE, `level_start`=1, `maze_flash`=0.
  - new_map still high on return to IDLE does not re-enter CLEAR until it has been seen low.
- pacman_died (not in CLEAR) → IDLE; all outputs clear, `combo`=0, no bonus issued.
- Reset: all outputs 0, state IDLE, all counters 0, `ate_q`=0.

## Timing
- All outputs are registered. Every response appears on the Clk edge that samples its cause; latency is 1 cycle.
- `pellet_ack`, `bonus_valid` and `level_start` are high for exactly one cycle.
- `bonus_points` holds its value until the next award; its reset value is 0.
- POWER lasts exactly POWER_FRAMES non-frozen ticks after the pellet rise.
- `ate_pellet` staying high after `pellet_ack` does not retrigger; only a fresh rise counts.
- Reset asserted mid-FREEZE or mid-CLEAR takes effect on the next edge with no pulses emitted.

## Test plan
Bench parameters: POWER=8, WARN=4, FLASH_PERIOD=2, FREEZE=3, CLEAR=4.
- **Pellet timing:** `ate_pellet` rise → next edge `frightened`=F and `pellet_ack` pulses once. After 8 ticks, state=IDLE and `frightened`=0. `flash` is 1 at `timer` 4 and 3, and 0 at 2 and 1.
- **Bonus chain:** in POWER, `ghost_caught`=4'b0110 held → ghost1 served for bonus 200, next cycle ghost2 for 400. `frightened`=4'b1001, FREEZE for 3 ticks, and `timer` does not change during the freeze.
- **Saturation and re-arm:** five captures across two pellets → bonus sequence 200, 400, 800, 1600, then 200 after the re-arm. `timer` reloads to 8 on the second rise.
- **Level clear:** `new_map` raised during FREEZE → CLEAR, `frightened`=0, `freeze`=1. After 4 ticks, `level_start` pulses once and state=IDLE.
- **Simultaneous events:** `pacman_died` and pellet rise in the same cycle → IDLE with no `pellet_ack`. `new_map` and `pacman_died` together → CLEAR.
- **Reset:** Reset during CLEAR → next edge all outputs 0 and state=0.
